// File: rtl/flip_flop_counter_4b_top_pkg.sv
// Shared constants for the free-running counter and its flop primitive.
package flip_flop_counter_4b_top_pkg;

    localparam int   CNT_WIDTH_DEFAULT = 4;
    localparam int   CNT_WIDTH_MIN     = 1;
    localparam int   CNT_WIDTH_MAX     = 16;
    localparam logic RESET_VAL         = 1'b0;

endpackage : flip_flop_counter_4b_top_pkg

// File: rtl/flip_flop_counter_4b_top_chk.sv
// Property checker for the counter: divider tracks count LSB, count steps by one.
module flip_flop_counter_4b_top_chk
    import flip_flop_counter_4b_top_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH_DEFAULT
) (
    input logic             clk,
    input logic             rst_n,
    input logic [WIDTH-1:0] bye,
    input logic             out_d
);

    if ((WIDTH < CNT_WIDTH_MIN) || (WIDTH > CNT_WIDTH_MAX)) begin : g_bad_width
        $error("flip_flop_counter_4b_top: WIDTH out of range");
    end

    a_div_tracks_lsb: assert property (@(posedge clk) disable iff (!rst_n)
        out_d == bye[0]);

    a_count_step: assert property (@(posedge clk) disable iff (!rst_n)
        rst_n |=> (bye == WIDTH'($past(bye) + 1'b1)));

endmodule : flip_flop_counter_4b_top_chk

// File: rtl/flip_flop_counter_4b_top_dff.sv
// Single-bit rising-edge D flop with asynchronous active-low clear.
module flip_flop_d_rise
    import flip_flop_counter_4b_top_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    // Storage bit: clears immediately on rst_n low, captures d on rising clk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RESET_VAL;
        end else begin
            q <= d;
        end
    end

endmodule : flip_flop_d_rise

// File: rtl/flip_flop_counter_4b_top.sv
// WIDTH-bit free-running up-counter with a separate divide-by-2 flop.
module flip_flop_counter_4b_top
    import flip_flop_counter_4b_top_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-1:0] bye,
    output logic             out_d
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] toggle_s;
    logic             div_q;
    logic             div_d;

    // Bit i toggles when every lower bit is one; computed per bit to avoid a carry loop
    for (genvar i = 0; i < WIDTH; i++) begin : g_inc
        if (i == 0) begin : g_lsb
            assign toggle_s[i] = 1'b1;
        end else begin : g_upper
            assign toggle_s[i] = &cnt_q[i-1:0];
        end
        assign cnt_d[i] = cnt_q[i] ^ toggle_s[i];

        flip_flop_d_rise u_cnt_bit (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (cnt_d[i]),
            .q     (cnt_q[i])
        );
    end

    assign div_d = ~div_q;

    flip_flop_d_rise u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (div_d),
        .q     (div_q)
    );

    assign bye   = cnt_q;
    assign out_d = div_q;

    flip_flop_counter_4b_top_chk #(
        .WIDTH (WIDTH)
    ) u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .bye   (bye),
        .out_d (out_d)
    );

endmodule : flip_flop_counter_4b_top

// File: tb/tb_flip_flop_counter_4b_top.sv
// Randomized bench: counter (WIDTH 4 and 2) and D flop against an arithmetic model.
module tb_flip_flop_counter_4b_top;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] bye;
    logic       out_d;
    logic [1:0] bye2;
    logic       out_d2;
    logic       d_u = 1'b0;
    logic       q_u;
    logic       d_prev;
    logic       q_hold;

    int  n_vec = 0;
    int  n_err = 0;
    int  edges = 0;   // rising edges counted since the last reset release
    time t_rise = 0;
    time t_prev_rise = 0;
    time t_fall = 0;

    always #5 clk = ~clk;

    flip_flop_counter_4b_top #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bye   (bye),
        .out_d (out_d)
    );

    flip_flop_counter_4b_top #(.WIDTH(2)) dut_w2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bye   (bye2),
        .out_d (out_d2)
    );

    flip_flop_d_rise u_dff (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (d_u),
        .q     (q_u)
    );

    // Edge timestamps of the divider output for period and duty checks
    always @(posedge out_d) begin
        t_prev_rise = t_rise;
        t_rise      = $time;
    end
    always @(negedge out_d) t_fall = $time;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_model();
        check("bye",    32'(bye),    32'(edges % 16));
        check("out_d",  32'(out_d),  32'(edges % 2));
        check("bye_w2", 32'(bye2),   32'(edges % 4));
        check("out_d2", 32'(out_d2), 32'(edges % 2));
    endtask

    // One clock cycle: rising edge, flop check, falling edge, model check, new d
    task automatic step();
        d_prev = d_u;
        @(posedge clk);
        #1;
        if (rst_n) edges++;
        check("dff_q", 32'(q_u), rst_n ? 32'(d_prev) : 32'd0);
        q_hold = q_u;
        @(negedge clk);
        check_model();
        d_u = ~d_u;
        #1;
        check("dff_negedge", 32'(q_u), 32'(q_hold));
    endtask

    // Assert reset between edges and confirm outputs clear before the next edge
    task automatic async_reset();
        #($urandom_range(1, 2));
        rst_n = 1'b0;
        #1;
        edges = 0;
        check_model();
        check("dff_rst", 32'(q_u), 32'd0);
        repeat ($urandom_range(1, 3)) step();
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        #1;
        check_model();
        check("dff_rst", 32'(q_u), 32'd0);
        @(posedge clk);
        #1;
        check_model();
        #6;
        rst_n = 1'b1;

        repeat (6) step();
        check("bye_six", 32'(bye), 32'd6);
        async_reset();
        step();
        check("bye_after_rst", 32'(bye), 32'd1);

        repeat (40) step();
        check("out_d_period", 32'(t_rise - t_prev_rise), 32'd20);
        check("out_d_half", (t_fall > t_rise) ? 32'(t_fall - t_rise) : 32'(t_rise - t_fall), 32'd10);

        for (int r = 0; r < 8; r++) begin
            repeat ($urandom_range(1, 40)) step();
            async_reset();
            repeat ($urandom_range(1, 20)) step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_flip_flop_counter_4b_top
